traffic_light_sequencer: RTL and testbench
==========================================

Name: traffic_light_sequencer

Overview:
- Downstream consumer of the time-parameter store in the traffic light controller.
- Runs the main/side-street light state machine and a 1 Hz-based countdown timer.
- Drives interval_code to select which stored duration it needs, and loads the returned 4-bit value, in seconds, into the timer.
- Also handles the side-street sensor extension and a latched pedestrian walk request.

Parameters:
- CLK_PER_SEC, default 50000000: clk cycles per one-second tick; the bench uses 4.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high; one clock; all state updates on posedge clk.
- sensor  in  1  side-street vehicle present, already synchronised.
- walk_request  in  1  pedestrian request; a single-cycle pulse suffices.
- prog_sync  in  1  new timing programmed; restart the sequence.
- value  in  4  duration in seconds for interval_code; registered upstream, valid 1 cycle after interval_code changes.
- interval_code  out  2  duration select: 00 = t_base, 01 = t_ext, 10 = t_yel; 11 is never driven.
- main_light  out  3  {red,yellow,green} one-hot.
- side_light  out  3  {red,yellow,green} one-hot.
- walk_lamp  out  1  pedestrian walk indicator.
- state_dbg  out  3  current state encoding, for debug.

Behaviour:

States, with interval code, lights, and exit on expiry:
- MG1: code 00, main G, side R -> MG2.
- MG2: code 01 if sensor was 1 on the MG1 expiry cycle, else 00; main G, side R -> MY.
- MY: code 10, main Y, side R -> WALK if walk_pending, else SG.
- WALK: code 01, main R, side R, walk_lamp=1 -> SG; clears walk_pending.
- SG: code 00, main R, side G -> SGX if sensor=1 on the SG expiry cycle, else SY.
- SGX: code 01, main R, side G -> SY.
- SY: code 10, main R, side Y -> MG1.

Encoding and outputs:
- State encoding MG1=0 … SY=6.
- All outputs are registered and change on the same edge as the state.

Per-state timing, with E = first cycle in the new state and interval_code updated in E:
- Cycle E+1: value is valid.
- Edge ending E+1: counter <= value (4 bits; value 0 is loaded as 1); the tick divider clears to 0.
- Divider counts 0..CLK_PER_SEC-1; tick = (divider == CLK_PER_SEC-1), after which it wraps to 0.
- Each tick decrements the counter.
- A tick with counter==1 is expiry: the state transitions on that edge.
- Dwell = value*CLK_PER_SEC + 2 cycles.

walk_pending:
- Set by walk_request=1 in any state except WALK; requests during WALK are ignored.
- Cleared on the WALK exit edge.

prog_sync=1:
- Next state is MG1, a fresh entry with code 00 and the timer reloaded as above.
- walk_pending is preserved.
- Takes priority over expiry in the same cycle.

reset=1:
- Next cycle: state MG1, interval_code 00, main_light 001, side_light 100, walk_lamp 0.
- walk_pending, counter and divider cleared; state_dbg 0.
- reset dominates prog_sync and walk_request.
- A reset mid-state (any state, including WALK) aborts immediately with no further lamp change.

Safety invariant: main_light and side_light are never both non-red in the same cycle.

Test Plan:
Bench setup: CLK_PER_SEC=4; a behavioural value source that registers its lookup, with 00->6, 10->2, 01->3.

1. Reset for 2 cycles then release, sensor=0, no walk -> dwell sequence:
   - MG1 26, MG2 26, MY 10, SG 26, SY 10 cycles.
   - Back to MG1 at cycle 98.
   - main_light/side_light follow the table; walk_lamp is always 0.
2. sensor=1 held -> MG2 selects code 01 with dwell 14; SG dwell 26, then SGX (code 01) dwell 14, then SY.
3. walk_request pulsed once mid-MG1 ->
   - After MY, enter WALK: 14 cycles, both lights 100, walk_lamp=1.
   - Then SG; walk_pending cleared, so the next cycle skips WALK.
   - A second pulse during WALK is ignored.
4. prog_sync pulsed mid-SG, same cycle as an expiry tick -> next cycle MG1, interval_code 00; MG1 dwell 26 measured from that entry.
5. Value source returns 0 for code 10 -> MY and SY dwell 6 cycles (treated as 1 s).
6. reset asserted mid-WALK together with prog_sync and walk_request -> next cycle MG1 outputs; walk_pending=0, so the following MY goes directly to SG.

Source files
------------

// File: rtl/traffic_light_sequencer.sv
// ---------------------------------------------------------------------------
// traffic_light_sequencer
//
// Purpose:
//   Main/side-street traffic light state machine with a one-second based
//   countdown timer. Each state asks the upstream time-parameter store for
//   its duration through interval_code, then loads the returned value
//   (seconds) into the timer. Handles the side-street sensor extension and
//   a latched pedestrian walk request.
//
// Ports:
//   clk           in   system clock
//   reset         in   synchronous, active-high reset
//   sensor        in   side-street vehicle present (already synchronised)
//   walk_request  in   pedestrian request, single-cycle pulse is enough
//   prog_sync     in   new timing programmed, restart the sequence at MG1
//   value         in   duration in seconds for the current interval_code,
//                      valid one cycle after interval_code changes
//   interval_code out  duration select: 00 t_base, 01 t_ext, 10 t_yel
//   main_light    out  main street {red,yellow,green}, one-hot
//   side_light    out  side street {red,yellow,green}, one-hot
//   walk_lamp     out  pedestrian walk indicator
//   state_dbg     out  current state encoding
// ---------------------------------------------------------------------------
module traffic_light_sequencer #(
    parameter int CLK_PER_SEC = 50000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       sensor,
    input  logic       walk_request,
    input  logic       prog_sync,
    input  logic [3:0] value,
    output logic [1:0] interval_code,
    output logic [2:0] main_light,
    output logic [2:0] side_light,
    output logic       walk_lamp,
    output logic [2:0] state_dbg
);

    localparam int DIV_W = (CLK_PER_SEC > 1) ? $clog2(CLK_PER_SEC) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_PER_SEC - 1);
    localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);

    localparam logic [2:0] LIGHT_R = 3'b100;
    localparam logic [2:0] LIGHT_Y = 3'b010;
    localparam logic [2:0] LIGHT_G = 3'b001;

    localparam logic [1:0] CODE_BASE = 2'b00;
    localparam logic [1:0] CODE_EXT  = 2'b01;
    localparam logic [1:0] CODE_YEL  = 2'b10;

    typedef enum logic [2:0] {
        MG1  = 3'd0,
        MG2  = 3'd1,
        MY   = 3'd2,
        WALK = 3'd3,
        SG   = 3'd4,
        SGX  = 3'd5,
        SY   = 3'd6
    } state_t;

    state_t           state;
    state_t           next_state;
    logic [1:0]       load_stage;
    logic [3:0]       counter;
    logic [DIV_W-1:0] divider;
    logic             walk_pending;

    logic             tick;
    logic             expiry;
    logic             advance;
    logic [1:0]       next_code;
    logic [2:0]       next_main;
    logic [2:0]       next_side;
    logic             next_walk_lamp;

    // load_stage walks 2 -> 1 -> 0 after every state entry: stage 2 is the
    // cycle where the new interval_code reaches the store, stage 1 is the
    // cycle where its value is valid and gets loaded. Ticks only run in 0.
    assign tick    = (load_stage == 2'd0) && (divider == DIV_LAST);
    assign expiry  = tick && (counter == 4'd1);
    assign advance = prog_sync || expiry;

    assign state_dbg = state;

    // Next-state selection; prog_sync outranks a same-cycle expiry.
    always_comb begin
        next_state = state;
        if (prog_sync) begin
            next_state = MG1;
        end else if (expiry) begin
            case (state)
                MG1:     next_state = MG2;
                MG2:     next_state = MY;
                MY:      next_state = walk_pending ? WALK : SG;
                WALK:    next_state = SG;
                SG:      next_state = sensor ? SGX : SY;
                SGX:     next_state = SY;
                SY:      next_state = MG1;
                default: next_state = MG1;
            endcase
        end
    end

    // Output values for the state being entered. They are only registered
    // on an advance, so sampling sensor here captures it on the MG1 expiry
    // cycle and holds the MG2 code for the whole of MG2.
    always_comb begin
        next_code      = CODE_BASE;
        next_main      = LIGHT_R;
        next_side      = LIGHT_R;
        next_walk_lamp = 1'b0;
        case (next_state)
            MG1: begin
                next_code = CODE_BASE;
                next_main = LIGHT_G;
            end
            MG2: begin
                next_code = sensor ? CODE_EXT : CODE_BASE;
                next_main = LIGHT_G;
            end
            MY: begin
                next_code = CODE_YEL;
                next_main = LIGHT_Y;
            end
            WALK: begin
                next_code      = CODE_EXT;
                next_walk_lamp = 1'b1;
            end
            SG: begin
                next_code = CODE_BASE;
                next_side = LIGHT_G;
            end
            SGX: begin
                next_code = CODE_EXT;
                next_side = LIGHT_G;
            end
            SY: begin
                next_code = CODE_YEL;
                next_side = LIGHT_Y;
            end
            default: begin
                next_code = CODE_BASE;
            end
        endcase
    end

    // Walk request latch. It clears only on the normal WALK exit; requests
    // during WALK are dropped, and a prog_sync restart leaves it pending.
    always_ff @(posedge clk) begin
        if (reset) begin
            walk_pending <= 1'b0;
        end else if ((state == WALK) && expiry && !prog_sync) begin
            walk_pending <= 1'b0;
        end else if (walk_request && (state != WALK)) begin
            walk_pending <= 1'b1;
        end
    end

    // State, registered outputs and the load/countdown timer.
    // A value of 0 is loaded as 1 so every state lasts at least one second.
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= MG1;
            interval_code <= CODE_BASE;
            main_light    <= LIGHT_G;
            side_light    <= LIGHT_R;
            walk_lamp     <= 1'b0;
            counter       <= 4'd0;
            divider       <= '0;
            load_stage    <= 2'd2;
        end else if (advance) begin
            state         <= next_state;
            interval_code <= next_code;
            main_light    <= next_main;
            side_light    <= next_side;
            walk_lamp     <= next_walk_lamp;
            divider       <= '0;
            load_stage    <= 2'd2;
        end else if (load_stage == 2'd2) begin
            load_stage <= 2'd1;
        end else if (load_stage == 2'd1) begin
            counter    <= (value == 4'd0) ? 4'd1 : value;
            divider    <= '0;
            load_stage <= 2'd0;
        end else begin
            if (tick) begin
                divider <= '0;
                counter <= counter - 4'd1;
            end else begin
                divider <= divider + DIV_ONE;
            end
        end
    end

endmodule

// File: tb/tb_traffic_light_sequencer.sv
// ---------------------------------------------------------------------------
// tb_traffic_light_sequencer
//
// Directed bench for traffic_light_sequencer with CLK_PER_SEC = 4 and a
// registered value source (code 00 -> 6 s, 01 -> 3 s, 10 -> 2 s, or 0 s
// when zero_yel is set). Inputs are driven and outputs sampled on the
// falling edge. Expected dwell per state is value*4 + 2 cycles.
// ---------------------------------------------------------------------------
module tb_traffic_light_sequencer;

    localparam int CPS = 4;

    localparam logic [2:0] R = 3'b100;
    localparam logic [2:0] Y = 3'b010;
    localparam logic [2:0] G = 3'b001;

    localparam logic [2:0] S_MG1  = 3'd0;
    localparam logic [2:0] S_MG2  = 3'd1;
    localparam logic [2:0] S_MY   = 3'd2;
    localparam logic [2:0] S_WALK = 3'd3;
    localparam logic [2:0] S_SG   = 3'd4;
    localparam logic [2:0] S_SGX  = 3'd5;
    localparam logic [2:0] S_SY   = 3'd6;

    logic       clk = 1'b0;
    logic       reset;
    logic       sensor;
    logic       walk_request;
    logic       prog_sync;
    logic [3:0] value;
    logic [1:0] interval_code;
    logic [2:0] main_light;
    logic [2:0] side_light;
    logic       walk_lamp;
    logic [2:0] state_dbg;
    logic       zero_yel;

    int checks = 0;
    int failures = 0;
    int total = 0;

    traffic_light_sequencer #(.CLK_PER_SEC(CPS)) dut (
        .clk          (clk),
        .reset        (reset),
        .sensor       (sensor),
        .walk_request (walk_request),
        .prog_sync    (prog_sync),
        .value        (value),
        .interval_code(interval_code),
        .main_light   (main_light),
        .side_light   (side_light),
        .walk_lamp    (walk_lamp),
        .state_dbg    (state_dbg)
    );

    always #5 clk = ~clk;

    // Behavioural time-parameter store with a registered lookup.
    always @(posedge clk) begin
        case (interval_code)
            2'b00:   value <= 4'd6;
            2'b01:   value <= 4'd3;
            2'b10:   value <= zero_yel ? 4'd0 : 4'd2;
            default: value <= 4'd0;
        endcase
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    // Drive one cycle of control inputs, then return them to idle.
    task automatic applyStimulus(input logic rst, input logic walk, input logic prog);
        reset        = rst;
        walk_request = walk;
        prog_sync    = prog;
        @(negedge clk);
        reset        = 1'b0;
        walk_request = 1'b0;
        prog_sync    = 1'b0;
    endtask

    // Called on the first sample in a state: checks its outputs, then counts
    // samples until the state changes. walk_at/prog_at pulse an input during
    // the cycle whose 1-based sample index matches (0 = never).
    task automatic measure_state(input string tag, input logic [2:0] exp_state,
                                 input logic [1:0] exp_code, input logic [2:0] exp_main,
                                 input logic [2:0] exp_side, input logic exp_walk,
                                 input int exp_dwell, input int walk_at, input int prog_at);
        int cnt;
        cnt = 1;
        checkOutput({tag, ".state"}, 32'(state_dbg), 32'(exp_state));
        checkOutput({tag, ".code"}, 32'(interval_code), 32'(exp_code));
        checkOutput({tag, ".main"}, 32'(main_light), 32'(exp_main));
        checkOutput({tag, ".side"}, 32'(side_light), 32'(exp_side));
        checkOutput({tag, ".walk"}, 32'(walk_lamp), 32'(exp_walk));
        while (cnt < 300) begin
            applyStimulus(1'b0, cnt == walk_at, cnt == prog_at);
            checkOutput({tag, ".safe"}, 32'((main_light != R) && (side_light != R)), 32'd0);
            if (state_dbg !== exp_state) break;
            cnt++;
        end
        checkOutput({tag, ".dwell"}, 32'(cnt), 32'(exp_dwell));
        total += cnt;
    endtask

    initial begin
        reset        = 1'b1;
        sensor       = 1'b0;
        walk_request = 1'b0;
        prog_sync    = 1'b0;
        zero_yel     = 1'b0;

        // Reset held for two cycles.
        @(negedge clk);
        checkOutput("rst.state", 32'(state_dbg), 32'(S_MG1));
        checkOutput("rst.code", 32'(interval_code), 32'd0);
        checkOutput("rst.main", 32'(main_light), 32'(G));
        checkOutput("rst.side", 32'(side_light), 32'(R));
        checkOutput("rst.walk", 32'(walk_lamp), 32'd0);
        @(negedge clk);
        reset = 1'b0;

        $display("[TB] basic cycle, no sensor, no walk");
        total = 0;
        measure_state("t1.MG1", S_MG1, 2'b00, G, R, 1'b0, 26, 0, 0);
        measure_state("t1.MG2", S_MG2, 2'b00, G, R, 1'b0, 26, 0, 0);
        measure_state("t1.MY",  S_MY,  2'b10, Y, R, 1'b0, 10, 0, 0);
        measure_state("t1.SG",  S_SG,  2'b00, R, G, 1'b0, 26, 0, 0);
        measure_state("t1.SY",  S_SY,  2'b10, R, Y, 1'b0, 10, 0, 0);
        checkOutput("t1.total", 32'(total), 32'd98);
        checkOutput("t1.back", 32'(state_dbg), 32'(S_MG1));

        $display("[TB] sensor held high");
        sensor = 1'b1;
        measure_state("t2.MG1", S_MG1, 2'b00, G, R, 1'b0, 26, 0, 0);
        measure_state("t2.MG2", S_MG2, 2'b01, G, R, 1'b0, 14, 0, 0);
        measure_state("t2.MY",  S_MY,  2'b10, Y, R, 1'b0, 10, 0, 0);
        measure_state("t2.SG",  S_SG,  2'b00, R, G, 1'b0, 26, 0, 0);
        measure_state("t2.SGX", S_SGX, 2'b01, R, G, 1'b0, 14, 0, 0);
        measure_state("t2.SY",  S_SY,  2'b10, R, Y, 1'b0, 10, 0, 0);
        sensor = 1'b0;

        $display("[TB] walk request");
        measure_state("t3.MG1",  S_MG1,  2'b00, G, R, 1'b0, 26, 5, 0);
        measure_state("t3.MG2",  S_MG2,  2'b00, G, R, 1'b0, 26, 0, 0);
        measure_state("t3.MY",   S_MY,   2'b10, Y, R, 1'b0, 10, 0, 0);
        measure_state("t3.WALK", S_WALK, 2'b01, R, R, 1'b1, 14, 3, 0);
        measure_state("t3.SG",   S_SG,   2'b00, R, G, 1'b0, 26, 0, 0);
        measure_state("t3.SY",   S_SY,   2'b10, R, Y, 1'b0, 10, 0, 0);
        measure_state("t3.MG1b", S_MG1,  2'b00, G, R, 1'b0, 26, 0, 0);
        measure_state("t3.MG2b", S_MG2,  2'b00, G, R, 1'b0, 26, 0, 0);
        measure_state("t3.MYb",  S_MY,   2'b10, Y, R, 1'b0, 10, 0, 0);
        measure_state("t3.SGb",  S_SG,   2'b00, R, G, 1'b0, 26, 0, 0);
        measure_state("t3.SYb",  S_SY,   2'b10, R, Y, 1'b0, 10, 0, 0);

        $display("[TB] prog_sync on the SG expiry cycle");
        measure_state("t4.MG1", S_MG1, 2'b00, G, R, 1'b0, 26, 0, 0);
        measure_state("t4.MG2", S_MG2, 2'b00, G, R, 1'b0, 26, 0, 0);
        measure_state("t4.MY",  S_MY,  2'b10, Y, R, 1'b0, 10, 0, 0);
        sensor = 1'b1;
        measure_state("t4.SG",  S_SG,  2'b00, R, G, 1'b0, 26, 0, 26);
        sensor = 1'b0;
        measure_state("t4.MGr", S_MG1, 2'b00, G, R, 1'b0, 26, 0, 0);

        $display("[TB] zero yellow duration");
        zero_yel = 1'b1;
        measure_state("t5.MG2", S_MG2, 2'b00, G, R, 1'b0, 26, 0, 0);
        measure_state("t5.MY",  S_MY,  2'b10, Y, R, 1'b0, 6, 0, 0);
        measure_state("t5.SG",  S_SG,  2'b00, R, G, 1'b0, 26, 0, 0);
        measure_state("t5.SY",  S_SY,  2'b10, R, Y, 1'b0, 6, 0, 0);
        zero_yel = 1'b0;

        $display("[TB] reset during WALK");
        measure_state("t6.MG1", S_MG1, 2'b00, G, R, 1'b0, 26, 3, 0);
        measure_state("t6.MG2", S_MG2, 2'b00, G, R, 1'b0, 26, 0, 0);
        measure_state("t6.MY",  S_MY,  2'b10, Y, R, 1'b0, 10, 0, 0);
        checkOutput("t6.inwalk", 32'(state_dbg), 32'(S_WALK));
        for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b1);
        measure_state("t6.rMG1", S_MG1, 2'b00, G, R, 1'b0, 26, 0, 0);
        measure_state("t6.rMG2", S_MG2, 2'b00, G, R, 1'b0, 26, 0, 0);
        measure_state("t6.rMY",  S_MY,  2'b10, Y, R, 1'b0, 10, 0, 0);
        measure_state("t6.rSG",  S_SG,  2'b00, R, G, 1'b0, 26, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
